// File: rtl/mpsoc_trace_termination_monitor.sv
// Per-tile trace monitor: shadows a result register per core, decodes terminate/print markers,
// arbitrates printed characters round-robin and runs a watchdog until every core has terminated.
module mpsoc_trace_termination_monitor #(
  parameter int               NUM_CORES  = 4,
  parameter int               XLEN       = 32,
  parameter int               RESULT_REG = 3,
  parameter logic [XLEN-1:0]  TERM_INSN  = XLEN'(32'h00100013),
  parameter logic [XLEN-1:0]  PUTC_INSN  = XLEN'(32'h00400013),
  parameter int               TMO_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CORES-1:0]      trace_valid,
  input  logic [NUM_CORES*XLEN-1:0] trace_insn,
  input  logic [NUM_CORES-1:0]      trace_wben,
  input  logic [NUM_CORES*5-1:0]    trace_wbreg,
  input  logic [NUM_CORES*XLEN-1:0] trace_wbdata,
  input  logic [TMO_W-1:0]          timeout_limit,
  output logic                      char_valid,
  input  logic                      char_ready,
  output logic [7:0]                char_data,
  output logic [3:0]                char_core,
  output logic                      char_overflow,
  output logic [NUM_CORES-1:0]      term_mask,
  output logic [4:0]                term_count,
  output logic                      all_terminated,
  output logic [XLEN-1:0]           exit_code,
  output logic                      fail,
  output logic                      timeout
);

  logic [XLEN-1:0]      shadow    [NUM_CORES];
  logic [7:0]           pend_data [NUM_CORES];
  logic [NUM_CORES-1:0] pend_valid;

  logic [NUM_CORES-1:0] wr_hit, term_hit, put_hit;
  logic [NUM_CORES-1:0] grant_oh, drain;
  logic                 grant_valid, load_out;
  logic [3:0]           grant_idx, rr_ptr;
  logic [7:0]           grant_data;
  logic [XLEN-1:0]      first_shadow;
  logic                 first_found, term_bad, ovf_hit;
  logic [TMO_W-1:0]     wd_count;

  // Marker decode; markers see the shadow value registered before this beat.
  always_comb begin
    wr_hit   = '0;
    term_hit = '0;
    put_hit  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      wr_hit[i]   = trace_valid[i] & trace_wben[i] & (trace_wbreg[i*5 +: 5] == 5'(RESULT_REG));
      term_hit[i] = trace_valid[i] & ~term_mask[i] & (trace_insn[i*XLEN +: XLEN] == TERM_INSN);
      put_hit[i]  = trace_valid[i] & ~term_mask[i] & (trace_insn[i*XLEN +: XLEN] == PUTC_INSN);
    end
  end

  always_comb begin
    first_shadow = '0;
    first_found  = 1'b0;
    term_bad     = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (term_hit[i]) begin
        if (!first_found) begin
          first_shadow = shadow[i];
          first_found  = 1'b1;
        end
        if (shadow[i] != '0) term_bad = 1'b1;
      end
    end
  end

  // Round-robin: first pass covers indices above rr_ptr, second pass wraps to 0..rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    grant_oh    = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (!grant_valid && pend_valid[j] && (j > int'(rr_ptr))) begin
        grant_valid = 1'b1;
        grant_idx   = 4'(j);
        grant_data  = pend_data[j];
        grant_oh[j] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_CORES; j++) begin
      if (!grant_valid && pend_valid[j] && (j <= int'(rr_ptr))) begin
        grant_valid = 1'b1;
        grant_idx   = 4'(j);
        grant_data  = pend_data[j];
        grant_oh[j] = 1'b1;
      end
    end
  end

  assign load_out = ~char_valid | char_ready;
  assign drain    = grant_oh & {NUM_CORES{load_out}};
  assign ovf_hit  = |(put_hit & pend_valid & ~drain);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the small per-core arrays are reset too, so a mid-run reset discards pending characters.
      for (int i = 0; i < NUM_CORES; i++) begin
        shadow[i]    <= '0;
        pend_data[i] <= '0;
      end
      pend_valid     <= '0;
      rr_ptr         <= 4'(NUM_CORES - 1);
      char_valid     <= 1'b0;
      char_data      <= '0;
      char_core      <= '0;
      char_overflow  <= 1'b0;
      term_mask      <= '0;
      term_count     <= '0;
      all_terminated <= 1'b0;
      exit_code      <= '0;
      fail           <= 1'b0;
      timeout        <= 1'b0;
      wd_count       <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (wr_hit[i]) shadow[i] <= trace_wbdata[i*XLEN +: XLEN];
        if (put_hit[i] && !(pend_valid[i] && !drain[i])) begin
          pend_valid[i] <= 1'b1;
          pend_data[i]  <= shadow[i][7:0];
        end else if (drain[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
      if (ovf_hit) char_overflow <= 1'b1;

      if (load_out) begin
        char_valid <= grant_valid;
        if (grant_valid) begin
          char_data <= grant_data;
          char_core <= grant_idx;
          rr_ptr    <= grant_idx;
        end
      end

      term_mask <= term_mask | term_hit;
      if (term_bad) fail <= 1'b1;
      if ((term_mask == '0) && first_found) exit_code <= first_shadow;
      term_count     <= 5'($countones(term_mask));
      all_terminated <= &term_mask;

      if (!all_terminated && (wd_count != '1)) wd_count <= wd_count + TMO_W'(1);
      if ((timeout_limit != '0) && (wd_count == timeout_limit)) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpsoc_trace_termination_monitor.sv
// Directed bench for mpsoc_trace_termination_monitor (4 cores): a per-cycle vector table for the
// character path plus hand-written sequences for termination, overflow and watchdog behaviour.
module tb_mpsoc_trace_termination_monitor;

  localparam int NC = 4;
  localparam logic [31:0] TERM = 32'h00100013;
  localparam logic [31:0] PUTC = 32'h00400013;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [1:0] OP_N = 2'd0, OP_P = 2'd1, OP_T = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] trace_valid = '0;
  logic [NC*32-1:0] trace_insn = '0;
  logic [NC-1:0] trace_wben = '0;
  logic [NC*5-1:0] trace_wbreg = '0;
  logic [NC*32-1:0] trace_wbdata = '0;
  logic [31:0]   timeout_limit = '0;
  logic          char_valid, char_ready = 1'b0;
  logic [7:0]    char_data;
  logic [3:0]    char_core;
  logic          char_overflow;
  logic [NC-1:0] term_mask;
  logic [4:0]    term_count;
  logic          all_terminated;
  logic [31:0]   exit_code;
  logic          fail, timeout;

  int n_pass = 0;
  int n_total = 0;

  mpsoc_trace_termination_monitor dut (
    .clk(clk), .rst(rst),
    .trace_valid(trace_valid), .trace_insn(trace_insn), .trace_wben(trace_wben),
    .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata), .timeout_limit(timeout_limit),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .char_core(char_core), .char_overflow(char_overflow), .term_mask(term_mask),
    .term_count(term_count), .all_terminated(all_terminated), .exit_code(exit_code),
    .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      v;
    logic [3:0][1:0] op;
    logic [3:0]      we;
    logic [3:0][7:0] d;
    logic            rdy;
    logic            e_cv;
    logic [7:0]      e_cd;
    logic [3:0]      e_cc;
    logic            e_ovf;
    logic [3:0]      e_tm;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic beat(input logic [3:0] v, input logic [3:0][1:0] op,
                      input logic [3:0] we, input logic [3:0][7:0] d);
    for (int i = 0; i < NC; i++) begin
      trace_valid[i]          = v[i];
      trace_wben[i]           = we[i];
      trace_wbreg[i*5 +: 5]   = 5'd3;
      trace_wbdata[i*32 +: 32] = {24'h0, d[i]};
      case (op[i])
        OP_P:    trace_insn[i*32 +: 32] = PUTC;
        OP_T:    trace_insn[i*32 +: 32] = TERM;
        default: trace_insn[i*32 +: 32] = NOP;
      endcase
    end
  endtask

  task automatic idle();
    beat('0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [7:0] op, input logic [3:0] we,
                              input logic [31:0] d, input logic rdy, input logic cv,
                              input logic [7:0] cd, input logic [3:0] cc);
    vec_t r;
    r.v = v; r.op = op; r.we = we; r.d = d; r.rdy = rdy;
    r.e_cv = cv; r.e_cd = cd; r.e_cc = cc; r.e_ovf = 1'b0; r.e_tm = 4'h0;
    return r;
  endfunction

  initial begin
    // Character path: cores 0,1,3 print a/b/d under 5 cycles of backpressure, then same-beat
    // write on core 2 (0x40 then 0x41), then a wrap-around pick (core 3 before core 0).
    tbl[0]  = mk(4'b1011, {OP_N, OP_N, OP_N, OP_N}, 4'b1011, 32'h64006261, 1'b0, 1'b0, 8'h00, 4'd0);
    tbl[1]  = mk(4'b1011, {OP_P, OP_N, OP_P, OP_P}, 4'b0000, 32'h0,        1'b0, 1'b0, 8'h00, 4'd0);
    tbl[2]  = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b0, 1'b1, 8'h61, 4'd0);
    tbl[3]  = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b0, 1'b1, 8'h61, 4'd0);
    tbl[4]  = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b0, 1'b1, 8'h61, 4'd0);
    tbl[5]  = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b0, 1'b1, 8'h61, 4'd0);
    tbl[6]  = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b1, 1'b1, 8'h62, 4'd1);
    tbl[7]  = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b1, 1'b1, 8'h64, 4'd3);
    tbl[8]  = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b1, 1'b0, 8'h00, 4'd0);
    tbl[9]  = mk(4'b0100, {OP_N, OP_N, OP_N, OP_N}, 4'b0100, 32'h00400000, 1'b1, 1'b0, 8'h00, 4'd0);
    tbl[10] = mk(4'b0100, {OP_N, OP_P, OP_N, OP_N}, 4'b0100, 32'h00410000, 1'b1, 1'b0, 8'h00, 4'd0);
    tbl[11] = mk(4'b0100, {OP_N, OP_P, OP_N, OP_N}, 4'b0000, 32'h0,        1'b1, 1'b1, 8'h40, 4'd2);
    tbl[12] = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b1, 1'b1, 8'h41, 4'd2);
    tbl[13] = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b1, 1'b0, 8'h00, 4'd0);
    tbl[14] = mk(4'b1001, {OP_P, OP_N, OP_N, OP_P}, 4'b0000, 32'h0, 1'b1, 1'b0, 8'h00, 4'd0);
    tbl[15] = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b1, 1'b1, 8'h64, 4'd3);
    tbl[16] = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b1, 1'b1, 8'h61, 4'd0);
    tbl[17] = mk(4'b0000, 8'h00, 4'b0000, 32'h0, 1'b1, 1'b0, 8'h00, 4'd0);

    // Reset state.
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst char_valid", 32'(char_valid), 32'd0);
    check("rst char_data", 32'(char_data), 32'd0);
    check("rst char_core", 32'(char_core), 32'd0);
    check("rst overflow", 32'(char_overflow), 32'd0);
    check("rst term_mask", 32'(term_mask), 32'd0);
    check("rst term_count", 32'(term_count), 32'd0);
    check("rst all_term", 32'(all_terminated), 32'd0);
    check("rst exit_code", exit_code, 32'd0);
    check("rst fail", 32'(fail), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      beat(tbl[i].v, tbl[i].op, tbl[i].we, tbl[i].d);
      char_ready = tbl[i].rdy;
      step();
      check($sformatf("v%0d char_valid", i), 32'(char_valid), 32'(tbl[i].e_cv));
      if (tbl[i].e_cv) begin
        check($sformatf("v%0d char_data", i), 32'(char_data), 32'(tbl[i].e_cd));
        check($sformatf("v%0d char_core", i), 32'(char_core), 32'(tbl[i].e_cc));
      end
      check($sformatf("v%0d overflow", i), 32'(char_overflow), 32'(tbl[i].e_ovf));
      check($sformatf("v%0d term_mask", i), 32'(term_mask), 32'(tbl[i].e_tm));
    end

    // Exit code from core 2, ignored prints after termination, first exit code kept.
    do_reset();
    char_ready = 1'b1;
    beat(4'b0100, '0, 4'b0100, 32'h002A0000); step();
    beat(4'b0100, {OP_N, OP_T, OP_N, OP_N}, 4'b0000, '0); step();
    check("ec term_mask", 32'(term_mask), 32'h4);
    check("ec exit_code", exit_code, 32'h2A);
    check("ec fail", 32'(fail), 32'd1);
    check("ec term_count lag", 32'(term_count), 32'd0);
    idle(); step();
    check("ec term_count", 32'(term_count), 32'd1);
    check("ec all_term", 32'(all_terminated), 32'd0);
    beat(4'b0100, {OP_N, OP_P, OP_N, OP_N}, 4'b0000, '0); step();
    idle(); step(); step();
    check("ec putc ignored", 32'(char_valid), 32'd0);
    beat(4'b0001, {OP_N, OP_N, OP_N, OP_T}, 4'b0000, '0); step();
    check("ec2 term_mask", 32'(term_mask), 32'h5);
    check("ec2 exit_code kept", exit_code, 32'h2A);
    idle(); step();
    check("ec2 term_count", 32'(term_count), 32'd2);

    // Simultaneous termination, shadows 0,5,0,0; watchdog must freeze before reaching 30.
    timeout_limit = 32'd30;
    do_reset();
    beat(4'b0010, '0, 4'b0010, 32'h00000500); step();
    beat(4'b1111, {OP_T, OP_T, OP_T, OP_T}, 4'b0000, '0); step();
    check("sim term_mask", 32'(term_mask), 32'hF);
    check("sim exit_code", exit_code, 32'd0);
    check("sim fail", 32'(fail), 32'd1);
    check("sim all_term lag", 32'(all_terminated), 32'd0);
    idle(); step();
    check("sim all_term", 32'(all_terminated), 32'd1);
    check("sim term_count", 32'(term_count), 32'd4);
    repeat (40) step();
    check("sim wd frozen", 32'(timeout), 32'd0);

    // Overflow: output holds 0x78, pend holds 0x79, 0x7A is dropped.
    timeout_limit = 32'd0;
    do_reset();
    char_ready = 1'b0;
    beat(4'b0010, '0, 4'b0010, 32'h00007800); step();
    beat(4'b0010, {OP_N, OP_N, OP_P, OP_N}, 4'b0010, 32'h00007900); step();
    check("ovf a valid", 32'(char_valid), 32'd0);
    beat(4'b0010, {OP_N, OP_N, OP_P, OP_N}, 4'b0010, 32'h00007A00); step();
    check("ovf b data", 32'(char_data), 32'h78);
    check("ovf b flag", 32'(char_overflow), 32'd0);
    beat(4'b0010, {OP_N, OP_N, OP_P, OP_N}, 4'b0000, '0); step();
    check("ovf c flag", 32'(char_overflow), 32'd1);
    idle(); step(); step();
    check("ovf hold valid", 32'(char_valid), 32'd1);
    check("ovf hold data", 32'(char_data), 32'h78);
    char_ready = 1'b1; step();
    check("ovf 2nd data", 32'(char_data), 32'h79);
    check("ovf 2nd core", 32'(char_core), 32'd1);
    step();
    check("ovf 3rd dropped", 32'(char_valid), 32'd0);
    check("ovf sticky", 32'(char_overflow), 32'd1);
    do_reset();
    #1;
    check("ovf cleared by rst", 32'(char_overflow), 32'd0);

    // Watchdog: limit 20 fires on edge 21 after release; async reset clears it and the counter.
    timeout_limit = 32'd20;
    do_reset();
    repeat (20) step();
    check("wd edge20", 32'(timeout), 32'd0);
    step();
    check("wd edge21", 32'(timeout), 32'd1);
    repeat (5) step();
    check("wd sticky", 32'(timeout), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("wd async clear", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) step();
    check("wd restart edge20", 32'(timeout), 32'd0);
    step();
    check("wd restart edge21", 32'(timeout), 32'd1);
    timeout_limit = 32'd0;
    do_reset();
    repeat (1000) step();
    check("wd disabled", 32'(timeout), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
